// File: rtl/poly_synth_engine.sv
// Polyphonic key-bitmap synthesizer: scans keys once per DAC sample tick, sums up to
// NUM_VOICES saw/square voices, mixes with the recorded input and saturates to the DAC width.
module poly_synth_engine #(
    parameter int unsigned NUM_VOICES = 4,
    parameter int unsigned KEY_W      = 32,
    parameter int unsigned PH_W       = 24,
    parameter int unsigned SAMPLE_W   = 16,
    parameter int unsigned BASE_INC   = 1000,
    parameter int unsigned STEP_INC   = 60
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst_n,
    input  logic                                 i_init_done,
    input  logic                                 i_sample_tick,
    input  logic [KEY_W-1:0]                     i_key,
    input  logic signed [SAMPLE_W-1:0]           i_rec_data,
    input  logic [1:0]                           i_mode,
    input  logic                                 i_wave,
    input  logic [2:0]                           i_shift,
    output logic signed [SAMPLE_W-1:0]           o_dac_data,
    output logic                                 o_valid,
    output logic [$clog2(NUM_VOICES+1)-1:0]      o_voices,
    output logic                                 o_overflow,
    output logic                                 o_tick_miss,
    output logic [2:0]                           o_state
);

    localparam int unsigned VC_W  = $clog2(NUM_VOICES + 1);
    localparam int unsigned IDX_W = (KEY_W > 1) ? $clog2(KEY_W) : 1;
    // NUM_VOICES < 2^VC_W, so VC_W extra bits hold the full-scale voice sum
    localparam int unsigned ACC_W = SAMPLE_W + VC_W;
    localparam int unsigned SUM_W = ACC_W + 1;

    localparam logic signed [SAMPLE_W-1:0] SQ_POS  = SAMPLE_W'(32'sd8192);
    localparam logic signed [SAMPLE_W-1:0] SQ_NEG  = SAMPLE_W'(-32'sd8192);
    localparam logic signed [SUM_W-1:0]    SAT_MAX = {{(SUM_W-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0]    SAT_MIN = ~SAT_MAX;

    typedef enum logic [2:0] {
        S_WAIT_INIT = 3'd0,
        S_IDLE      = 3'd1,
        S_SCAN      = 3'd2,
        S_MIX       = 3'd3,
        S_OUT       = 3'd4
    } state_t;

    state_t                      r_state;
    state_t                      w_next;

    logic [PH_W-1:0]             r_phase [KEY_W];
    logic [IDX_W-1:0]            r_idx;
    logic signed [ACC_W-1:0]     r_acc;
    logic [VC_W-1:0]             r_count;
    logic signed [SAMPLE_W-1:0]  r_result;
    logic signed [SAMPLE_W-1:0]  r_dac;
    logic                        r_valid;
    logic [VC_W-1:0]             r_voices;
    logic                        r_overflow;
    logic                        r_tick_miss;

    logic [PH_W-1:0]             w_cur_phase;
    logic [PH_W-1:0]             w_inc;
    logic                        w_key_on;
    logic                        w_voice_free;
    logic                        w_last_idx;
    logic signed [SAMPLE_W-1:0]  w_wave;
    logic signed [ACC_W-1:0]     w_wave_ext;
    logic signed [ACC_W-1:0]     w_synth;
    logic signed [SUM_W-1:0]     w_synth_ext;
    logic signed [SUM_W-1:0]     w_rec_ext;
    logic signed [SUM_W-1:0]     w_mix;
    logic                        w_sat_hi;
    logic                        w_sat_lo;
    logic signed [SAMPLE_W-1:0]  w_sat;

    // Per-key voice generation for the currently visited index
    assign w_cur_phase  = r_phase[r_idx];
    assign w_inc        = PH_W'(BASE_INC) + PH_W'(PH_W'(r_idx) * PH_W'(STEP_INC));
    assign w_key_on     = i_key[r_idx];
    assign w_voice_free = (r_count < VC_W'(NUM_VOICES));
    assign w_last_idx   = (r_idx == IDX_W'(KEY_W - 1));

    always_comb begin
        w_wave = w_cur_phase[PH_W-1 -: SAMPLE_W];
        if (i_wave) begin
            w_wave = w_cur_phase[PH_W-1] ? SQ_NEG : SQ_POS;
        end
    end

    assign w_wave_ext = ACC_W'(w_wave);

    // Output mix and saturation
    assign w_synth     = r_acc >>> i_shift;
    assign w_synth_ext = SUM_W'(w_synth);
    assign w_rec_ext   = SUM_W'(i_rec_data);

    always_comb begin
        w_mix = '0;
        case (i_mode)
            2'd0:    w_mix = w_synth_ext;
            2'd1:    w_mix = w_rec_ext;
            2'd2:    w_mix = w_synth_ext + w_rec_ext;
            default: w_mix = '0;
        endcase
    end

    assign w_sat_hi = (w_mix > SAT_MAX);
    assign w_sat_lo = (w_mix < SAT_MIN);
    assign w_sat    = w_sat_hi ? SAMPLE_W'(SAT_MAX) :
                      w_sat_lo ? SAMPLE_W'(SAT_MIN) : SAMPLE_W'(w_mix);

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_WAIT_INIT;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; losing codec init aborts from anywhere
    always_comb begin
        w_next = r_state;
        if (!i_init_done) begin
            w_next = S_WAIT_INIT;
        end else begin
            case (r_state)
                S_WAIT_INIT: w_next = S_IDLE;
                S_IDLE:      if (i_sample_tick) w_next = S_SCAN;
                S_SCAN:      if (w_last_idx) w_next = S_MIX;
                S_MIX:       w_next = S_OUT;
                S_OUT:       w_next = S_IDLE;
                default:     w_next = S_WAIT_INIT;
            endcase
        end
    end

    // Datapath, phases and registered outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < KEY_W; i++) begin
                r_phase[i] <= '0;
            end
            r_idx       <= '0;
            r_acc       <= '0;
            r_count     <= '0;
            r_result    <= '0;
            r_dac       <= '0;
            r_valid     <= 1'b0;
            r_voices    <= '0;
            r_overflow  <= 1'b0;
            r_tick_miss <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (i_sample_tick && (r_state != S_IDLE)) begin
                r_tick_miss <= 1'b1;
            end
            if (!i_init_done) begin
                r_dac <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_idx   <= '0;
                        r_acc   <= '0;
                        r_count <= '0;
                    end
                    S_SCAN: begin
                        r_idx <= r_idx + IDX_W'(1);
                        if (!w_key_on) begin
                            r_phase[r_idx] <= '0;
                        end else if (w_voice_free) begin
                            r_acc          <= r_acc + w_wave_ext;
                            r_phase[r_idx] <= w_cur_phase + w_inc;
                            r_count        <= r_count + VC_W'(1);
                        end else begin
                            r_overflow <= 1'b1;
                        end
                    end
                    S_MIX: begin
                        r_result <= w_sat;
                        if (w_sat_hi || w_sat_lo) begin
                            r_overflow <= 1'b1;
                        end
                    end
                    S_OUT: begin
                        r_dac    <= r_result;
                        r_voices <= r_count;
                        r_valid  <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign o_dac_data  = r_dac;
    assign o_valid     = r_valid;
    assign o_voices    = r_voices;
    assign o_overflow  = r_overflow;
    assign o_tick_miss = r_tick_miss;
    assign o_state     = r_state;

endmodule

// File: doc/poly_synth_engine.md
POLY_SYNTH_ENGINE -- requirements
Module: poly_synth_engine

Interface
REQ-001 SHALL have parameter NUM_VOICES, default 4: max simultaneously sounding keys.
REQ-002 SHALL have parameter KEY_W, default 32: width of key bitmap, one bit per key.
REQ-003 SHALL have parameter PH_W, default 24: per-key phase accumulator width.
REQ-004 SHALL have parameter SAMPLE_W, default 16: signed audio sample width.
REQ-005 SHALL have parameters BASE_INC (default 1000) and STEP_INC (default 60): key k phase increment = BASE_INC + k*STEP_INC, modulo 2^PH_W.
REQ-006 SHALL have port i_clk  input  1  the single system clock; all logic on its rising edge.
REQ-007 SHALL have port i_rst_n  input  1  reset, asynchronous and active-low.
REQ-008 SHALL have port i_init_done  input  1  codec I2C init finished (level).
REQ-009 SHALL have port i_sample_tick  input  1  one-cycle strobe per DAC sample, already synchronous to i_clk.
REQ-010 SHALL have port i_key  input  KEY_W  pressed-key bitmap, bit k = key k held.
REQ-011 SHALL have port i_rec_data  input  SAMPLE_W  signed recorded/ADC sample.
REQ-012 SHALL have port i_mode  input  2  0 synth, 1 record, 2 synth+record, 3 mute.
REQ-013 SHALL have port i_wave  input  1  0 sawtooth, 1 square.
REQ-014 SHALL have port i_shift  input  3  arithmetic right shift applied to voice sum.
REQ-015 SHALL have port o_dac_data  output  SAMPLE_W  signed sample to DAC serializer, held between updates.
REQ-016 SHALL have port o_valid  output  1  one-cycle pulse when o_dac_data updates.
REQ-017 SHALL have port o_voices  output  clog2(NUM_VOICES+1)  voices sounded in last sample.
REQ-018 SHALL have ports o_overflow and o_tick_miss  output  1 each  sticky flags.
REQ-019 SHALL have port o_state  output  3  current FSM state encoding.

Function
REQ-020 SHALL implement states WAIT_INIT=0, IDLE=1, SCAN=2, MIX=3, OUT=4.
REQ-021 WAIT_INIT -> IDLE on i_init_done=1; any state -> WAIT_INIT the cycle after i_init_done=0, with o_dac_data forced 0 and scan aborted.
REQ-022 IDLE -> SCAN on i_sample_tick=1; index, accumulator and voice count cleared on entry.
REQ-023 SCAN SHALL visit key index 0..KEY_W-1, one per cycle, lowest index first.
REQ-024 Per visited key k: if i_key[k]=1 and count<NUM_VOICES, add wave(phase[k]) to accumulator, then phase[k] += inc(k) wrapping, count++.
REQ-025 Pressed key beyond NUM_VOICES SHALL be skipped (phase held) and set o_overflow.
REQ-026 Released key (i_key[k]=0 when visited) SHALL have phase[k] cleared to 0.
REQ-027 Saw wave = signed value of phase[PH_W-1 -: SAMPLE_W]; square wave = +8192 if phase MSB=0 else -8192.
REQ-028 Accumulator SHALL be wide enough for NUM_VOICES full-scale samples without wrap.
REQ-029 MIX (one cycle): synth = accumulator >>> i_shift; result per i_mode: 0 synth, 1 i_rec_data, 2 synth+i_rec_data, 3 zero.
REQ-030 Result SHALL saturate to [-2^(SAMPLE_W-1), 2^(SAMPLE_W-1)-1]; saturation sets o_overflow.
REQ-031 OUT: register o_dac_data, o_voices, pulse o_valid for exactly one cycle, return to IDLE.
REQ-032 Latency: tick in cycle T -> o_valid in cycle T+KEY_W+3.
REQ-033 i_sample_tick outside IDLE SHALL be ignored and set o_tick_miss.
REQ-034 i_mode, i_wave, i_shift SHALL be sampled in MIX/SCAN as used; i_key sampled per visited index.
REQ-035 o_overflow and o_tick_miss SHALL clear only on reset.

Reset
REQ-036 On i_rst_n=0: state WAIT_INIT, all phases 0, o_dac_data 0, o_valid 0, o_voices 0, flags 0, immediately and asynchronously.
REQ-037 Reset asserted mid-SCAN SHALL discard partial sum; no o_valid emitted.

Verification
REQ-038 Defaults, i_key=bit0, saw, shift 0, mode 0, two ticks -> outputs 0 then 3 (1000>>8), o_voices=1.
REQ-039 Five lowest keys pressed, square, shift 0, mode 0 -> sum 40960 limited to 4 voices=32768, saturates 32767, o_voices=4, o_overflow=1.
REQ-040 Mode 2, i_rec_data=30000, key0 square -> o_dac_data=32767; mode 1, i_rec_data=-5 -> -5; mode 3 -> 0.
REQ-041 Tick again 5 cycles after first tick -> o_tick_miss=1, only one o_valid.
REQ-042 Drop i_init_done mid-SCAN -> o_state=0, o_dac_data=0, no o_valid; re-raise -> IDLE, next tick produces valid sample.
REQ-043 Key0 held 3 ticks, released 1 tick, re-pressed -> first sample after re-press is saw 0 (phase cleared).
